// File: rtl/bas_controller.sv
// Beetle-antennae-search sequencer: two antenna probes, one position update and one re-evaluation per iteration.
// Six cycles per iteration with zero waits; stalls indefinitely on dir_valid and eval_ack.
module bas_controller #(
  parameter int MAX_ITER    = 100,
  parameter int DECAY_SHIFT = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic signed [15:0] init_x,
  input  logic signed [15:0] init_y,
  input  logic signed [13:0] init_step,
  input  logic               dir_valid,
  input  logic signed [8:0]  dir_x_in,
  input  logic signed [8:0]  dir_y_in,
  output logic               dir_ready,
  output logic               eval_req,
  output logic signed [15:0] eval_x,
  output logic signed [15:0] eval_y,
  input  logic               eval_ack,
  input  logic signed [31:0] eval_odour,
  output logic signed [13:0] move,
  output logic signed [8:0]  dir_x,
  output logic signed [8:0]  dir_y,
  output logic signed [31:0] odour_left,
  output logic signed [31:0] odour_right,
  output logic signed [15:0] x,
  output logic signed [15:0] y,
  input  logic signed [15:0] updated_x,
  input  logic signed [15:0] updated_y,
  output logic               busy,
  output logic               done,
  output logic [9:0]         iter_count,
  output logic signed [15:0] best_x,
  output logic signed [15:0] best_y,
  output logic signed [31:0] best_odour
);

  typedef enum logic [3:0] {
    IDLE, EVAL_INIT, GET_DIR, EVAL_L, EVAL_R, UPDATE, EVAL_NEW, DECAY, DONE
  } state_t;

  state_t state;

  logic signed [8:0]  off_dir_x;
  logic signed [8:0]  off_dir_y;
  logic signed [22:0] prod_x;
  logic signed [22:0] prod_y;
  logic signed [13:0] off_x;
  logic signed [13:0] off_y;
  logic signed [13:0] step_load;
  logic signed [13:0] move_dec;
  logic signed [13:0] move_next;
  logic               dir_fire;
  logic               last_iter;

  assign dir_fire = dir_valid && dir_ready;

  // The left-antenna point is issued on the same edge that latches the direction,
  // so the offset must come straight from the direction input while in GET_DIR.
  assign off_dir_x = (state == GET_DIR) ? dir_x_in : dir_x;
  assign off_dir_y = (state == GET_DIR) ? dir_y_in : dir_y;
  assign prod_x    = 23'(move) * 23'(off_dir_x);
  assign prod_y    = 23'(move) * 23'(off_dir_y);
  assign off_x     = 14'(prod_x >>> 8);
  assign off_y     = 14'(prod_y >>> 8);

  assign step_load = (init_step <= 14'sd0) ? 14'sd1 : init_step;
  assign move_dec  = move - (move >>> DECAY_SHIFT);
  assign move_next = (move_dec < 14'sd1) ? 14'sd1 : move_dec;
  assign last_iter = (iter_count + 10'd1) == 10'(MAX_ITER);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      eval_req    <= 1'b0;
      eval_x      <= '0;
      eval_y      <= '0;
      dir_ready   <= 1'b0;
      move        <= '0;
      dir_x       <= '0;
      dir_y       <= '0;
      x           <= '0;
      y           <= '0;
      odour_left  <= '0;
      odour_right <= '0;
      best_x      <= '0;
      best_y      <= '0;
      best_odour  <= '0;
      iter_count  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            x          <= init_x;
            y          <= init_y;
            move       <= step_load;
            iter_count <= '0;
            busy       <= 1'b1;
            eval_req   <= 1'b1;
            eval_x     <= init_x;
            eval_y     <= init_y;
            state      <= EVAL_INIT;
          end
        end
        EVAL_INIT: begin
          if (eval_ack) begin
            best_x     <= x;
            best_y     <= y;
            best_odour <= eval_odour;
            eval_req   <= 1'b0;
            dir_ready  <= 1'b1;
            state      <= GET_DIR;
          end
        end
        GET_DIR: begin
          if (dir_fire) begin
            dir_x     <= dir_x_in;
            dir_y     <= dir_y_in;
            dir_ready <= 1'b0;
            eval_req  <= 1'b1;
            eval_x    <= x - 16'(off_x);
            eval_y    <= y - 16'(off_y);
            state     <= EVAL_L;
          end
        end
        EVAL_L: begin
          if (eval_ack) begin
            odour_left <= eval_odour;
            eval_x     <= x + 16'(off_x);
            eval_y     <= y + 16'(off_y);
            state      <= EVAL_R;
          end
        end
        EVAL_R: begin
          if (eval_ack) begin
            odour_right <= eval_odour;
            eval_req    <= 1'b0;
            state       <= UPDATE;
          end
        end
        UPDATE: begin
          x        <= updated_x;
          y        <= updated_y;
          eval_req <= 1'b1;
          eval_x   <= updated_x;
          eval_y   <= updated_y;
          state    <= EVAL_NEW;
        end
        EVAL_NEW: begin
          if (eval_ack) begin
            // Strict compare: an equal odour keeps the earlier best point.
            if (eval_odour > best_odour) begin
              best_x     <= x;
              best_y     <= y;
              best_odour <= eval_odour;
            end
            eval_req <= 1'b0;
            state    <= DECAY;
          end
        end
        DECAY: begin
          move       <= move_next;
          iter_count <= iter_count + 10'd1;
          if (last_iter) begin
            state <= DONE;
          end else begin
            dir_ready <= 1'b1;
            state     <= GET_DIR;
          end
        end
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/bas_controller.md
BAS_CONTROLLER -- requirements
Module: bas_controller

Interface
REQ-001 SHALL have parameter MAX_ITER, default 100: number of search iterations per run (1..1023).
REQ-002 SHALL have parameter DECAY_SHIFT, default 4: step decay, step_next = step - (step >>> DECAY_SHIFT).
REQ-003 SHALL use one clock; reset is asynchronous and active-low: clk input 1 (rising edge), rst_n input 1 (active-low asynchronous reset).
REQ-004 SHALL have ports:
- start in 1: begin a run, sampled in IDLE only.
- init_x, init_y in 16 signed: start position.
- init_step in 14 signed: initial step size.
- dir_valid in 1, dir_x_in, dir_y_in in 9 signed Q1.8: random unit direction source.
- dir_ready out 1.
- eval_req out 1, eval_x, eval_y out 16 signed: fitness request.
- eval_ack in 1, eval_odour in 32 signed: fitness response.
- move out 14 signed, dir_x, dir_y out 9 signed, odour_left, odour_right out 32 signed, x, y out 16 signed: drive the beetle_position datapath.
- updated_x, updated_y in 16 signed: returned by the datapath.
- busy out 1, done out 1, iter_count out 10.
- best_x, best_y out 16 signed, best_odour out 32 signed.

Function
REQ-005 States SHALL be IDLE, EVAL_INIT, GET_DIR, EVAL_L, EVAL_R, UPDATE, EVAL_NEW, DECAY, DONE.
REQ-006 IDLE + start SHALL load x=init_x, y=init_y, move=init_step (clamped to 1 if <=0), iter_count=0, then go to EVAL_INIT; busy is 1 in every state except IDLE.
REQ-007 GET_DIR SHALL assert dir_ready; on dir_valid&&dir_ready it SHALL latch dir_x/dir_y and go to EVAL_L; otherwise it stalls.
REQ-008 Antenna offset SHALL be off_x = (move*dir_x) >>> 8, computed as a 23-bit signed product and truncated to 14 bits; off_y is computed the same way.
REQ-009 EVAL_L SHALL request (x-off_x, y-off_y) and latch the result into odour_left; EVAL_R SHALL request (x+off_x, y+off_y) and latch the result into odour_right. Position adds wrap in 16-bit two's complement, with no saturation.
REQ-010 Eval handshake:
- eval_req and eval_x/eval_y are registered and stay stable while in an EVAL_* state.
- The odour is captured on the first edge with eval_ack=1.
- eval_req drops in the following cycle.
- eval_ack outside an EVAL_* state SHALL be ignored.
REQ-011 UPDATE SHALL register x<=updated_x, y<=updated_y (one cycle). With the datapath, left>right moves negative; a tie moves positive.
REQ-012 EVAL_NEW SHALL request (x,y). If eval_odour > best_odour (strict), it SHALL update best_x/best_y/best_odour; a tie keeps the old best.
REQ-013 EVAL_INIT SHALL request the start position and unconditionally load best_* with it.
REQ-014 DECAY SHALL:
- Set move <= move - (move>>>DECAY_SHIFT), floored at 1.
- Increment iter_count.
- Go to DONE if iter_count+1 == MAX_ITER, else go to GET_DIR.
REQ-015 DONE SHALL pulse done for exactly one cycle and return to IDLE. x, y, best_*, iter_count and move SHALL hold until the next start.
REQ-016 start while busy SHALL be ignored.
REQ-017 Minimum iteration length SHALL be 6 cycles (zero-wait dir_valid/eval_ack), plus stall cycles.

Reset
REQ-018 rst_n low SHALL asynchronously force IDLE and zero every output: busy, done, eval_req, dir_ready, move, dir_*, x, y, odour_*, best_*, iter_count.
REQ-019 Reset mid-run SHALL abort immediately. A pending eval_ack after release SHALL be ignored, and there SHALL be no done pulse.

Verification
REQ-020 Basic run:
- Stimulus: init (0,0), step 256, dir (128,0), odour = x, MAX_ITER=1, immediate acks.
- Required: eval points (-128,0) then (128,0); x=128 after UPDATE; move=240; done one cycle; best_x=128, best_odour=128.
REQ-021 Tie:
- Stimulus: odour constant 5.
- Required: x increases by off_x each iteration; best stays at init position (strict compare).
REQ-022 Step floor:
- Stimulus: init_step=1, DECAY_SHIFT=4, MAX_ITER=3.
- Required: move stays 1 all run; init_step=-7 loads move=1.
REQ-023 Stalls:
- Stimulus: eval_ack delayed 3 cycles and dir_valid delayed 2 cycles.
- Required: eval_req/eval_x/eval_y stay stable throughout the delay; the odour is latched on the ack cycle only.
REQ-024 Reset mid-EVAL_R:
- Stimulus: assert rst_n low mid-EVAL_R.
- Required: all outputs 0 the same cycle; a stray ack after release is ignored; a new start runs cleanly with iter_count from 0.
REQ-025 Start and timing:
- Stimulus: start during busy, MAX_ITER=2.
- Required: the run is unaffected; done is asserted exactly 1+2*6+1 cycles after EVAL_INIT entry with zero waits; iter_count=2.
